rep3_tx_encoder: RTL and testbench

- Transmit end of the triple-repetition bit link; the receive end recovers each bit by 3-input majority vote.
- Accepts a parallel word on a valid/ready input handshake, then serializes it MSB first, emitting every data bit as 3 consecutive identical symbols on a valid/ready symbol output.
- Sits between a word producer and the serial channel or line driver.

---
 rtl/rep3_pkg.sv | 19 +
 rtl/rep3_sym_counter.sv | 44 ++++
 rtl/rep3_tx_encoder.sv | 108 ++++++++++
 tb/tb_rep3_tx_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep3_pkg.sv
// Shared definitions for the triple-repetition transmit encoder.
// Holds the repetition factor, the FSM state type, the repetition counter
// width and the even-parity helper used by the encoder and its testbench.
package rep3_pkg;

    localparam int REP_FACTOR = 3;
    localparam int REP_CNT_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Even parity of a word, zero-extended to 32 bits by the caller.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rep3_sym_counter.sv
// Symbol position tracker for the repetition encoder.
// rep_cnt counts repeats of the current bit (0..REP_FACTOR-1), bit_cnt counts
// bits already sent. shift_pulse fires on the transfer that completes a bit,
// last flags the final symbol of the frame.
module rep3_sym_counter
    import rep3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NBITS  = DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic shift_pulse,
    output logic last
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [REP_CNT_W-1:0] REP_MAX  = REP_CNT_W'(REP_FACTOR - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(NBITS - 1);

    logic [REP_CNT_W-1:0] rep_cnt;
    logic [BIT_W-1:0]     bit_cnt;

    // Step the repeat counter on each transfer and roll into the next bit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rep_cnt <= '0;
            bit_cnt <= '0;
        end else if (advance) begin
            if (rep_cnt < REP_MAX) begin
                rep_cnt <= rep_cnt + 1'b1;
            end else begin
                rep_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign shift_pulse = advance && (rep_cnt == REP_MAX);
    assign last        = (bit_cnt == BIT_LAST) && (rep_cnt == REP_MAX);

endmodule

// File: rtl/rep3_tx_encoder.sv
// Transmit side of the triple-repetition bit link.
// Accepts a word on a valid/ready handshake and serializes it MSB first,
// sending every bit as three identical symbols on a valid/ready output.
// Optional feature: define REP3_TX_PARITY_EN to append an even-parity bit
// (also repeated three times) after the LSB.
module rep3_tx_encoder
    import rep3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy
);

`ifdef REP3_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] sh;
    logic [NBITS-1:0] capture_word;
    logic             take;
    logic             advance;
    logic             shift_pulse;
    logic             last;

    assign take    = (state == IDLE) && in_valid;
    assign advance = (state == SEND) && tx_ready;

`ifdef REP3_TX_PARITY_EN
    assign capture_word = {in_data, even_parity(32'(in_data))};
`else
    assign capture_word = in_data;
`endif

    rep3_sym_counter #(
        .DATA_W (DATA_W),
        .NBITS  (NBITS)
    ) u_sym_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == IDLE),
        .advance     (advance),
        .shift_pulse (shift_pulse),
        .last        (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave IDLE on a handshake, return after the last symbol.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = SEND;
            SEND: if (tx_ready && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        in_ready = 1'b0;
        tx_valid = 1'b0;
        tx_bit   = 1'b0;
        tx_last  = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            SEND: begin
                tx_valid = 1'b1;
                tx_bit   = sh[NBITS-1];
                tx_last  = last;
                busy     = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Shift register: load on capture, shift left once per completed bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (take) begin
            sh <= capture_word;
        end else if (shift_pulse) begin
            sh <= sh << 1;
        end
    end

endmodule

// File: tb/tb_rep3_tx_encoder.sv
// Self-checking testbench for rep3_tx_encoder.
// Expected symbol streams are built from the word bits (MSB first, each bit
// three times, optional parity triplet) and compared with what the DUT emits.
module tb_rep3_tx_encoder;
    import rep3_pkg::*;

    localparam int DATA_W = 8;
`ifdef REP3_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int FRAME = 3 * NBITS;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              busy;

    int n_checks;
    int n_fail;

    logic obs_bit[$];
    logic obs_last[$];
    logic exp_q[$];
    int   stall_changes;
    int   frame_cycles;
    int   invalid_cycles;
    int   ready_busy;
    bit   timed_out;

    rep3_tx_encoder #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: append the symbol stream of one word to exp_q.
    function automatic void add_expected(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--)
            for (int r = 0; r < 3; r++) exp_q.push_back(w[i]);
`ifdef REP3_TX_PARITY_EN
        for (int r = 0; r < 3; r++) exp_q.push_back(even_parity(32'(w)));
`endif
    endfunction

    function automatic int seq_mismatches();
        int m = 0;
        for (int i = 0; i < obs_bit.size() && i < exp_q.size(); i++)
            if (obs_bit[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic int last_mismatches();
        int m = 0;
        for (int i = 0; i < obs_last.size(); i++)
            if (obs_last[i] !== (((i + 1) % FRAME) == 0)) m++;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] decode_word(input int base);
        logic [DATA_W-1:0] w = '0;
        int votes;
        for (int b = 0; b < DATA_W; b++) begin
            votes = 0;
            for (int r = 0; r < 3; r++)
                if (base + 3 * b + r < obs_bit.size() && obs_bit[base + 3 * b + r] === 1'b1) votes++;
            w[DATA_W - 1 - b] = (votes >= 2);
        end
        return w;
    endfunction

    // Present a word and hold it until the handshake edge has passed.
    task automatic start_word(input logic [DATA_W-1:0] w, output bit ok);
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Drain one frame, recording transferred symbols and stall behaviour.
    task automatic collect_frame(input bit random_bp);
        bit   prev_stalled;
        logic prev_bit;
        logic prev_last;
        bit   done;
        obs_bit.delete();
        obs_last.delete();
        stall_changes  = 0;
        frame_cycles   = 0;
        invalid_cycles = 0;
        ready_busy     = 0;
        timed_out      = 1'b0;
        prev_stalled   = 1'b0;
        prev_bit       = 1'b0;
        prev_last      = 1'b0;
        done           = 1'b0;
        for (int cyc = 0; cyc < FRAME * 20 && !done; cyc++) begin
            tx_ready = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            frame_cycles++;
            if (prev_stalled && (tx_bit !== prev_bit || tx_last !== prev_last)) stall_changes++;
            if (tx_valid !== 1'b1) invalid_cycles++;
            if (in_ready !== 1'b0) ready_busy++;
            if (tx_valid === 1'b1 && tx_ready) begin
                obs_bit.push_back(tx_bit);
                obs_last.push_back(tx_last);
                if (tx_last === 1'b1) done = 1'b1;
            end
            prev_stalled = (tx_valid === 1'b1) && !tx_ready;
            prev_bit     = tx_bit;
            prev_last    = tx_last;
            @(posedge clk);
            #1;
        end
        timed_out = !done;
        tx_ready  = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            rst      = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks += 4;
            if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_valid cyc=%0d got=%b exp=0", c, tx_valid); end
            if (tx_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_last cyc=%0d got=%b exp=0", c, tx_last); end
            if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy cyc=%0d got=%b exp=0", c, busy); end
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_tx_valid got=%b exp=0", tx_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        bit ok;
        exp_q.delete();
        add_expected(8'hA5);
        start_word(8'hA5, ok);
        collect_frame(1'b0);
        n_checks += 6;
        if (!ok) begin n_fail++; $display("[TB] FAIL single_handshake got=0 exp=1"); end
        if (timed_out || obs_bit.size() != FRAME) begin n_fail++; $display("[TB] FAIL single_len got=%0d exp=%0d", obs_bit.size(), FRAME); end
        if (seq_mismatches() != 0) begin n_fail++; $display("[TB] FAIL single_seq mismatching_symbols=%0d exp=0", seq_mismatches()); end
        if (last_mismatches() != 0) begin n_fail++; $display("[TB] FAIL single_last misplaced=%0d exp=0", last_mismatches()); end
        if (frame_cycles != FRAME) begin n_fail++; $display("[TB] FAIL single_cycles got=%0d exp=%0d", frame_cycles, FRAME); end
        if (invalid_cycles != 0 || ready_busy != 0) begin n_fail++; $display("[TB] FAIL single_busy_flags invalid=%0d ready=%0d exp=0", invalid_cycles, ready_busy); end
        @(negedge clk);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_after_in_ready got=%b exp=1", in_ready); end
        if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_after_tx_valid got=%b exp=0", tx_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_q.delete();
        add_expected(8'h3C);
        start_word(8'h3C, ok);
        collect_frame(1'b1);
        n_checks += 5;
        if (timed_out || obs_bit.size() != FRAME) begin n_fail++; $display("[TB] FAIL bp_len got=%0d exp=%0d", obs_bit.size(), FRAME); end
        if (seq_mismatches() != 0) begin n_fail++; $display("[TB] FAIL bp_seq mismatching_symbols=%0d exp=0", seq_mismatches()); end
        if (last_mismatches() != 0) begin n_fail++; $display("[TB] FAIL bp_last misplaced=%0d exp=0", last_mismatches()); end
        if (stall_changes != 0) begin n_fail++; $display("[TB] FAIL bp_stall_stable changes=%0d exp=0", stall_changes); end
        if (decode_word(0) !== 8'h3C) begin n_fail++; $display("[TB] FAIL bp_decode got=%h exp=3c", decode_word(0)); end
    endtask

    task automatic test_back_to_back();
        int hs;
        int frames_done;
        int idle_gap;
        int busy_ready;
        exp_q.delete();
        add_expected(8'hFF);
        add_expected(8'h00);
        obs_bit.delete();
        obs_last.delete();
        hs = 0; frames_done = 0; idle_gap = 0; busy_ready = 0;
        tx_ready = 1'b1;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 4 * FRAME && frames_done < 2; cyc++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && in_valid) hs++;
            if (tx_valid === 1'b1) begin
                if (in_ready !== 1'b0) busy_ready++;
                obs_bit.push_back(tx_bit);
                obs_last.push_back(tx_last);
                if (tx_last === 1'b1) frames_done++;
            end else if (frames_done == 1) begin
                idle_gap++;
            end
            @(posedge clk);
            #1;
            if (hs >= 1) in_data = 8'h00;
        end
        in_valid = 1'b0;
        n_checks += 6;
        if (obs_bit.size() != 2 * FRAME) begin n_fail++; $display("[TB] FAIL b2b_len got=%0d exp=%0d", obs_bit.size(), 2 * FRAME); end
        if (seq_mismatches() != 0) begin n_fail++; $display("[TB] FAIL b2b_seq mismatching_symbols=%0d exp=0", seq_mismatches()); end
        if (last_mismatches() != 0) begin n_fail++; $display("[TB] FAIL b2b_last misplaced=%0d exp=0", last_mismatches()); end
        if (idle_gap != 1) begin n_fail++; $display("[TB] FAIL b2b_gap got=%0d exp=1", idle_gap); end
        if (hs != 2) begin n_fail++; $display("[TB] FAIL b2b_handshakes got=%0d exp=2", hs); end
        if (busy_ready != 0) begin n_fail++; $display("[TB] FAIL b2b_ready_while_busy got=%0d exp=0", busy_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n_xfer;
        bit saw_last;
        n_xfer = 0;
        saw_last = 1'b0;
        start_word(8'h81, ok);
        for (int i = 0; i < 10; i++) begin
            tx_ready = 1'b1;
            @(negedge clk);
            if (tx_valid === 1'b1) n_xfer++;
            if (tx_last === 1'b1) saw_last = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        if (tx_last === 1'b1) saw_last = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks += 5;
        if (n_xfer != 10) begin n_fail++; $display("[TB] FAIL mid_xfers got=%0d exp=10", n_xfer); end
        if (saw_last) begin n_fail++; $display("[TB] FAIL mid_no_last got=1 exp=0"); end
        if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_tx_valid got=%b exp=0", tx_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_in_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0 || tx_last !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy_last got=%b%b exp=00", busy, tx_last); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        add_expected(8'h01);
        start_word(8'h01, ok);
        collect_frame(1'b0);
        n_checks += 3;
        if (timed_out || obs_bit.size() != FRAME) begin n_fail++; $display("[TB] FAIL mid_fresh_len got=%0d exp=%0d", obs_bit.size(), FRAME); end
        if (seq_mismatches() != 0) begin n_fail++; $display("[TB] FAIL mid_fresh_seq mismatching_symbols=%0d exp=0", seq_mismatches()); end
        if (last_mismatches() != 0) begin n_fail++; $display("[TB] FAIL mid_fresh_last misplaced=%0d exp=0", last_mismatches()); end
    endtask

`ifdef REP3_TX_PARITY_EN
    task automatic test_parity();
        bit ok;
        int tail_ones;
        exp_q.delete();
        add_expected(8'h07);
        start_word(8'h07, ok);
        collect_frame(1'b0);
        tail_ones = 0;
        for (int i = FRAME - 9; i >= 0 && i < obs_bit.size(); i++)
            if (obs_bit[i] === 1'b1) tail_ones++;
        n_checks += 3;
        if (obs_bit.size() != 27) begin n_fail++; $display("[TB] FAIL parity_len got=%0d exp=27", obs_bit.size()); end
        if (tail_ones != 9) begin n_fail++; $display("[TB] FAIL parity_tail ones=%0d exp=9", tail_ones); end
        if (last_mismatches() != 0) begin n_fail++; $display("[TB] FAIL parity_last misplaced=%0d exp=0", last_mismatches()); end
    endtask
`endif

    task automatic test_random_words();
        bit ok;
        logic [DATA_W-1:0] w;
        for (int k = 0; k < 5; k++) begin
            w = DATA_W'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            exp_q.delete();
            add_expected(w);
            start_word(w, ok);
            collect_frame(1'b1);
            n_checks += 4;
            if (timed_out || obs_bit.size() != FRAME) begin n_fail++; $display("[TB] FAIL rand_len word=%h got=%0d exp=%0d", w, obs_bit.size(), FRAME); end
            if (seq_mismatches() != 0) begin n_fail++; $display("[TB] FAIL rand_seq word=%h mismatching_symbols=%0d exp=0", w, seq_mismatches()); end
            if (last_mismatches() != 0 || stall_changes != 0) begin n_fail++; $display("[TB] FAIL rand_last_stall word=%h last=%0d stall=%0d exp=0", w, last_mismatches(), stall_changes); end
            if (decode_word(0) !== w) begin n_fail++; $display("[TB] FAIL rand_decode got=%h exp=%h", decode_word(0), w); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tx_ready = 1'b1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef REP3_TX_PARITY_EN
        test_parity();
`endif
        test_random_words();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
